// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
// Centre-samples each bit; one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int FREQ = 50_000_000,
  parameter int RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int CNT_MAX   = FREQ / RATE - 1;
  localparam int HALF      = CNT_MAX / 2;
  localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_TOP =
    CNT_WIDTH'(CNT_MAX);
  localparam logic [CNT_WIDTH-1:0] CNT_MID =
    CNT_WIDTH'(HALF);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    BIT0,
    BIT1,
    BIT2,
    BIT3,
    BIT4,
    BIT5,
    BIT6,
    BIT7,
    STOP,
    WAIT
  } state_e;

  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [7:0]           sh;
  logic                 rx_m;
  logic                 rx_s;
  logic                 cnt_end;
  logic                 in_bit;
  logic                 bit_tick;

  assign cnt_end  = (cnt == CNT_TOP);
  assign in_bit   = (state >= BIT0) && (state <= BIT7);
  assign bit_tick = in_bit && cnt_end;

  // Two-flop synchroniser; idles high so reset looks like a quiet line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // Data bits arrive LSB first, so shift in from the top
  always_ff @(posedge clk) begin
    if (bit_tick) begin
      sh <= {rx_s, sh[7:1]};
    end
  end

  // Frame FSM, bit-period counter and registered output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      cnt         <= cnt + CNT_ONE;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : BIT0;
          end
        end
        STOP: begin
          if (cnt_end) begin
            cnt <= '0;
            if (rx_s) begin
              o_data  <= sh;
              o_valid <= 1'b1;
              state   <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          if (!in_bit) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt_end) begin
            cnt   <= '0;
            state <= state_e'(state + 4'd1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a
// frame-level expectation model of the receiver.
module tb_uart_rx;

  localparam int F0   = 16;
  localparam int R0   = 1;
  localparam int D    = F0 / R0;
  localparam int HALF = (D - 1) / 2;
  localparam int LAT  = 1 + 3 + HALF + 9 * D;

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         c;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx0;
  logic       rx1;
  logic [7:0] o_data0;
  logic       o_valid0;
  logic       o_err0;
  logic [7:0] o_data1;
  logic       o_valid1;
  logic       o_err1;

  int   cyc;
  int   total;
  int   bad;
  int   both;
  ev_t  q0[$];
  ev_t  q1[$];
  ev_t  exp_q[$];
  logic [7:0] last_good;

  uart_rx #(.FREQ(F0), .RATE(R0)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (rx0),
    .o_data      (o_data0),
    .o_valid     (o_valid0),
    .o_frame_err (o_err0)
  );

  uart_rx u_def (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (rx1),
    .o_data      (o_data1),
    .o_valid     (o_valid1),
    .o_frame_err (o_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid0 || o_err0)
      q0.push_back('{o_err0, o_data0, cyc});
    if (o_valid1 || o_err1)
      q1.push_back('{o_err1, o_data1, cyc});
    if ((o_valid0 && o_err0) || (o_valid1 && o_err1))
      both = both + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one frame on the fast DUT; lim>0 aborts after lim cycles.
  task automatic send(
    input logic [7:0] b,
    input bit         stop,
    input int         lim
  );
    logic [9:0] fr;
    int         k;
    fr = {stop, b, 1'b0};
    k  = cyc;
    if (lim == 0) begin
      if (stop) begin
        exp_q.push_back('{1'b0, b, k + LAT});
        last_good = b;
      end else begin
        exp_q.push_back('{1'b1, last_good, k + LAT});
      end
    end
    for (int c = 0; c < 10 * D; c++) begin
      rx0 = fr[c / D];
      @(negedge clk);
      if (lim > 0 && c + 1 == lim) return;
    end
  endtask

  task automatic idle(input int n);
    rx0 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_n"}, q0.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
      chk({tag, "_err"}, 32'(q0[i].err), 32'(exp_q[i].err));
      chk({tag, "_dat"}, 32'(q0[i].d), 32'(exp_q[i].d));
      chk({tag, "_cyc"}, q0[i].c, exp_q[i].c);
    end
    q0.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rb;
    bit         rs;
    int         gap;
    total     = 0;
    bad       = 0;
    both      = 0;
    last_good = 8'h00;
    rx0       = 1'b1;
    rx1       = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(o_data0), 0);
    chk("rst_valid", 32'(o_valid0), 0);
    chk("rst_err", 32'(o_err0), 0);
    rst_n = 1'b1;
    idle(5);

    send(8'hA5, 1'b1, 0);
    idle(10);
    cmp("a5");

    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    send(8'h3C, 1'b1, 0);
    idle(10);
    cmp("b2b");

    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    idle(20);
    cmp("glitch");
    send(8'h5A, 1'b1, 0);
    idle(10);
    cmp("post_glitch");

    send(8'h81, 1'b0, 0);
    repeat (100) @(negedge clk);
    idle(20);
    cmp("ferr");
    chk("ferr_hold", 32'(o_data0), 32'(last_good));
    send(8'h42, 1'b1, 0);
    idle(10);
    cmp("post_ferr");

    send(8'hC3, 1'b1, 3 + 3 + HALF + 3 * D + 8);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(o_data0), 0);
    chk("arst_valid", 32'(o_valid0), 0);
    chk("arst_err", 32'(o_err0), 0);
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    last_good = 8'h00;
    idle(10);
    cmp("arst");
    send(8'h18, 1'b1, 0);
    idle(10);
    cmp("post_arst");

    for (int i = 0; i < 12; i++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 3) != 0);
      gap = rs ? $urandom_range(0, 12)
               : $urandom_range(4, 30);
      send(rb, rs, 0);
      idle(gap);
    end
    idle(10);
    cmp("rand");

    q1.delete();
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10; i++) begin
        rx1 = fr[i];
        repeat (425) @(negedge clk);
      end
      rx1 = 1'b1;
    end
    repeat (50) @(negedge clk);
    chk("def_n", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("def_err", 32'(q1[0].err), 0);
      chk("def_dat", 32'(q1[0].d), 32'h55);
    end

    chk("excl", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
